// File: rtl/eth_tx_arbiter.sv
// eth_tx_arbiter: frame-level arbiter sharing the 10G MAC transmit AXI-stream
// between the NetTLP encapsulated-TLP path (s0) and the control-plane responder (s1).
// Whole frames are granted at a time. Granted beats pass through combinationally.
// A frame that runs past MAX_BEATS is cut with an error marker, and its tail is drained.
module eth_tx_arbiter #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned KEEP_WIDTH = 8,
  parameter int unsigned MAX_BEATS  = 192,
  parameter int unsigned PRIO_MODE  = 0,
  parameter int unsigned CNT_WIDTH  = 32
) (
  input  logic                  clk156,
  input  logic                  sys_rst156,
  input  logic                  s0_tvalid,
  output logic                  s0_tready,
  input  logic [DATA_WIDTH-1:0] s0_tdata,
  input  logic [KEEP_WIDTH-1:0] s0_tkeep,
  input  logic                  s0_tlast,
  input  logic                  s1_tvalid,
  output logic                  s1_tready,
  input  logic [DATA_WIDTH-1:0] s1_tdata,
  input  logic [KEEP_WIDTH-1:0] s1_tkeep,
  input  logic                  s1_tlast,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic [KEEP_WIDTH-1:0] m_tkeep,
  output logic                  m_tlast,
  output logic                  m_tuser,
  output logic [CNT_WIDTH-1:0]  frame_cnt0,
  output logic [CNT_WIDTH-1:0]  frame_cnt1,
  output logic [CNT_WIDTH-1:0]  trunc_cnt
);

  localparam int unsigned BEAT_W = (MAX_BEATS > 2) ? $clog2(MAX_BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(MAX_BEATS - 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_GRANT0 = 3'd1;
  localparam logic [2:0] ST_GRANT1 = 3'd2;
  localparam logic [2:0] ST_FLUSH0 = 3'd3;
  localparam logic [2:0] ST_FLUSH1 = 3'd4;

  logic [2:0]           state_q, state_d;
  logic                 last_grant_q, last_grant_d;
  logic [BEAT_W-1:0]    beat_cnt_q, beat_cnt_d;
  logic [CNT_WIDTH-1:0] frame_cnt0_q, frame_cnt0_d;
  logic [CNT_WIDTH-1:0] frame_cnt1_q, frame_cnt1_d;
  logic [CNT_WIDTH-1:0] trunc_cnt_q, trunc_cnt_d;

  logic                  sel_s1;
  logic                  sel_tvalid;
  logic [DATA_WIDTH-1:0] sel_tdata;
  logic [KEEP_WIDTH-1:0] sel_tkeep;
  logic                  sel_tlast;
  logic                  at_limit;
  logic                  trunc_beat;

  // Select the source owned by the current grant/flush state
  always_comb begin
    sel_s1     = (state_q == ST_GRANT1) || (state_q == ST_FLUSH1);
    sel_tvalid = sel_s1 ? s1_tvalid : s0_tvalid;
    sel_tdata  = sel_s1 ? s1_tdata  : s0_tdata;
    sel_tkeep  = sel_s1 ? s1_tkeep  : s0_tkeep;
    sel_tlast  = sel_s1 ? s1_tlast  : s0_tlast;
    at_limit   = (beat_cnt_q == LAST_BEAT);
    trunc_beat = at_limit && !sel_tlast;
  end

  // Next-state, counter and stream output logic
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    beat_cnt_d   = beat_cnt_q;
    frame_cnt0_d = frame_cnt0_q;
    frame_cnt1_d = frame_cnt1_q;
    trunc_cnt_d  = trunc_cnt_q;
    m_tvalid     = 1'b0;
    m_tdata      = '0;
    m_tkeep      = '0;
    m_tlast      = 1'b0;
    m_tuser      = 1'b0;
    s0_tready    = 1'b0;
    s1_tready    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Ties go to s1 in fixed-priority mode, else to the source not served last
        if (s0_tvalid && s1_tvalid) begin
          if ((PRIO_MODE != 0) || !last_grant_q) begin
            state_d      = ST_GRANT1;
            last_grant_d = 1'b1;
          end else begin
            state_d      = ST_GRANT0;
            last_grant_d = 1'b0;
          end
        end else if (s0_tvalid) begin
          state_d      = ST_GRANT0;
          last_grant_d = 1'b0;
        end else if (s1_tvalid) begin
          state_d      = ST_GRANT1;
          last_grant_d = 1'b1;
        end
      end

      ST_GRANT0, ST_GRANT1: begin
        m_tvalid = sel_tvalid;
        m_tdata  = sel_tdata;
        m_tkeep  = sel_tkeep;
        m_tlast  = sel_tlast || trunc_beat;
        m_tuser  = trunc_beat && sel_tvalid;
        if (sel_s1) begin
          s1_tready = m_tready;
        end else begin
          s0_tready = m_tready;
        end
        if (sel_tvalid && m_tready) begin
          if (sel_tlast) begin
            beat_cnt_d = '0;
            state_d    = ST_IDLE;
            if (sel_s1) begin
              frame_cnt1_d = frame_cnt1_q + CNT_WIDTH'(1);
            end else begin
              frame_cnt0_d = frame_cnt0_q + CNT_WIDTH'(1);
            end
          end else if (at_limit) begin
            beat_cnt_d  = '0;
            trunc_cnt_d = trunc_cnt_q + CNT_WIDTH'(1);
            state_d     = sel_s1 ? ST_FLUSH1 : ST_FLUSH0;
          end else begin
            beat_cnt_d = beat_cnt_q + BEAT_W'(1);
          end
        end
      end

      ST_FLUSH0, ST_FLUSH1: begin
        // Swallow the tail of a truncated frame up to and including its tlast
        if (sel_s1) begin
          s1_tready = 1'b1;
        end else begin
          s0_tready = 1'b1;
        end
        if (sel_tvalid && sel_tlast) begin
          beat_cnt_d = '0;
          state_d    = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and counter registers
  always_ff @(posedge clk156) begin
    if (sys_rst156) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      beat_cnt_q   <= '0;
      frame_cnt0_q <= '0;
      frame_cnt1_q <= '0;
      trunc_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
      frame_cnt0_q <= frame_cnt0_d;
      frame_cnt1_q <= frame_cnt1_d;
      trunc_cnt_q  <= trunc_cnt_d;
    end
  end

  assign frame_cnt0 = frame_cnt0_q;
  assign frame_cnt1 = frame_cnt1_q;
  assign trunc_cnt  = trunc_cnt_q;

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Testbench for eth_tx_arbiter: two instances (round-robin / MAX_BEATS=6 and
// fixed-priority / MAX_BEATS=4) driven by random frame sources, checked by a
// frame-level reference model with per-source expected-beat queues.
module tb_eth_tx_arbiter;

  localparam int unsigned DW = 64;
  localparam int unsigned KW = 8;
  localparam int unsigned CW = 32;
  localparam int MAXB0 = 6;
  localparam int MAXB1 = 4;
  localparam int MD_IDLE  = 0;
  localparam int MD_BUSY  = 1;
  localparam int MD_FLUSH = 2;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic        user;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          s_tvalid [2][2];
  logic          s_tlast  [2][2];
  logic [DW-1:0] s_tdata  [2][2];
  logic [KW-1:0] s_tkeep  [2][2];
  logic          m_tready [2];

  logic          d0_s0_tready, d0_s1_tready, d0_m_tvalid, d0_m_tlast, d0_m_tuser;
  logic [DW-1:0] d0_m_tdata;
  logic [KW-1:0] d0_m_tkeep;
  logic [CW-1:0] d0_fc0, d0_fc1, d0_tc;
  logic          d1_s0_tready, d1_s1_tready, d1_m_tvalid, d1_m_tlast, d1_m_tuser;
  logic [DW-1:0] d1_m_tdata;
  logic [KW-1:0] d1_m_tkeep;
  logic [CW-1:0] d1_fc0, d1_fc1, d1_tc;

  logic          o_s_tready [2][2];
  logic          o_m_tvalid [2];
  logic          o_m_tlast  [2];
  logic          o_m_tuser  [2];
  logic [DW-1:0] o_m_tdata  [2];
  logic [KW-1:0] o_m_tkeep  [2];
  logic [CW-1:0] o_fc0 [2];
  logic [CW-1:0] o_fc1 [2];
  logic [CW-1:0] o_tc  [2];

  eth_tx_arbiter #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .MAX_BEATS(MAXB0), .PRIO_MODE(0), .CNT_WIDTH(CW)) u_dut0 (
    .clk156(clk), .sys_rst156(rst),
    .s0_tvalid(s_tvalid[0][0]), .s0_tready(d0_s0_tready), .s0_tdata(s_tdata[0][0]),
    .s0_tkeep(s_tkeep[0][0]), .s0_tlast(s_tlast[0][0]),
    .s1_tvalid(s_tvalid[0][1]), .s1_tready(d0_s1_tready), .s1_tdata(s_tdata[0][1]),
    .s1_tkeep(s_tkeep[0][1]), .s1_tlast(s_tlast[0][1]),
    .m_tvalid(d0_m_tvalid), .m_tready(m_tready[0]), .m_tdata(d0_m_tdata),
    .m_tkeep(d0_m_tkeep), .m_tlast(d0_m_tlast), .m_tuser(d0_m_tuser),
    .frame_cnt0(d0_fc0), .frame_cnt1(d0_fc1), .trunc_cnt(d0_tc)
  );

  eth_tx_arbiter #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .MAX_BEATS(MAXB1), .PRIO_MODE(1), .CNT_WIDTH(CW)) u_dut1 (
    .clk156(clk), .sys_rst156(rst),
    .s0_tvalid(s_tvalid[1][0]), .s0_tready(d1_s0_tready), .s0_tdata(s_tdata[1][0]),
    .s0_tkeep(s_tkeep[1][0]), .s0_tlast(s_tlast[1][0]),
    .s1_tvalid(s_tvalid[1][1]), .s1_tready(d1_s1_tready), .s1_tdata(s_tdata[1][1]),
    .s1_tkeep(s_tkeep[1][1]), .s1_tlast(s_tlast[1][1]),
    .m_tvalid(d1_m_tvalid), .m_tready(m_tready[1]), .m_tdata(d1_m_tdata),
    .m_tkeep(d1_m_tkeep), .m_tlast(d1_m_tlast), .m_tuser(d1_m_tuser),
    .frame_cnt0(d1_fc0), .frame_cnt1(d1_fc1), .trunc_cnt(d1_tc)
  );

  // Gather both instances' outputs into indexable arrays
  always_comb begin
    o_s_tready[0][0] = d0_s0_tready;  o_s_tready[0][1] = d0_s1_tready;
    o_s_tready[1][0] = d1_s0_tready;  o_s_tready[1][1] = d1_s1_tready;
    o_m_tvalid[0] = d0_m_tvalid;  o_m_tvalid[1] = d1_m_tvalid;
    o_m_tlast[0]  = d0_m_tlast;   o_m_tlast[1]  = d1_m_tlast;
    o_m_tuser[0]  = d0_m_tuser;   o_m_tuser[1]  = d1_m_tuser;
    o_m_tdata[0]  = d0_m_tdata;   o_m_tdata[1]  = d1_m_tdata;
    o_m_tkeep[0]  = d0_m_tkeep;   o_m_tkeep[1]  = d1_m_tkeep;
    o_fc0[0] = d0_fc0;  o_fc0[1] = d1_fc0;
    o_fc1[0] = d0_fc1;  o_fc1[1] = d1_fc1;
    o_tc[0]  = d0_tc;   o_tc[1]  = d1_tc;
  end

  // Scoreboard: expected output beats per instance and source
  beat_t exp_q [2][2][$];

  int checks = 0;
  int errors = 0;
  bit done;
  bit drain_to;

  // ------------------------------------------------------------------
  // Stimulus: random frame sources and MAC ready patterns
  // ------------------------------------------------------------------
  int          act  [2][2];
  int          idx  [2][2];
  int          len  [2][2];
  int          seq  [2][2];
  logic [31:0] seed [2][2];
  logic [7:0]  lkeep[2][2];
  int          start_pct;
  int          valid_pct;
  int          rdy_mode;
  bit          stop_gen;

  function automatic logic [63:0] beat_data(input int d, input int s, input int i);
    return {4'(d), 4'(s), 16'(seq[d][s]), 8'(i), seed[d][s] ^ (32'(i) * 32'h9E3779B9)};
  endfunction

  // Start a frame and predict what the MAC side must see for it
  task automatic new_frame(input int d, input int s);
    int    maxb;
    beat_t e;
    maxb = (d == 0) ? MAXB0 : MAXB1;
    seq[d][s]   = seq[d][s] + 1;
    seed[d][s]  = $urandom;
    len[d][s]   = int'($urandom_range(maxb + 3, 1));
    lkeep[d][s] = 8'($urandom_range(255, 1));
    idx[d][s]   = 0;
    act[d][s]   = 1;
    for (int i = 0; i < len[d][s] && i < maxb; i++) begin
      e.data = beat_data(d, s, i);
      e.keep = (i == len[d][s] - 1) ? lkeep[d][s] : 8'hFF;
      e.last = (i == len[d][s] - 1) || (i == maxb - 1);
      e.user = (i == maxb - 1) && (len[d][s] > maxb);
      exp_q[d][s].push_back(e);
    end
  endtask

  task automatic src_step(input int d, input int s, input bit acc);
    if (acc) begin
      idx[d][s] = idx[d][s] + 1;
      if (idx[d][s] == len[d][s]) act[d][s] = 0;
    end
    if (act[d][s] == 0 && !stop_gen && $urandom_range(99) < start_pct) new_frame(d, s);
    if (act[d][s] != 0) begin
      if (!s_tvalid[d][s] || acc) s_tvalid[d][s] = ($urandom_range(99) < valid_pct);
      s_tdata[d][s] = beat_data(d, s, idx[d][s]);
      s_tkeep[d][s] = (idx[d][s] == len[d][s] - 1) ? lkeep[d][s] : 8'hFF;
      s_tlast[d][s] = (idx[d][s] == len[d][s] - 1);
    end else begin
      s_tvalid[d][s] = 1'b0;
      s_tlast[d][s]  = 1'b0;
    end
  endtask

  task automatic step_all();
    bit acc [2][2];
    @(negedge clk);
    for (int d = 0; d < 2; d++)
      for (int s = 0; s < 2; s++)
        acc[d][s] = s_tvalid[d][s] && o_s_tready[d][s];
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      for (int s = 0; s < 2; s++) src_step(d, s, acc[d][s]);
      case (rdy_mode)
        0:       m_tready[d] = 1'b1;
        1:       m_tready[d] = 1'($urandom_range(1));
        default: m_tready[d] = ~m_tready[d];
      endcase
    end
  endtask

  task automatic clear_sources();
    for (int d = 0; d < 2; d++)
      for (int s = 0; s < 2; s++) begin
        act[d][s] = 0;
        s_tvalid[d][s] = 1'b0;
        s_tlast[d][s]  = 1'b0;
        exp_q[d][s].delete();
      end
  endtask

  task automatic run(input int n, input int sp, input int vp, input int rm);
    start_pct = sp;
    valid_pct = vp;
    rdy_mode  = rm;
    repeat (n) step_all();
  endtask

  initial begin
    bit hit;
    bit busy;
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      m_tready[d] = 1'b1;
      for (int s = 0; s < 2; s++) begin
        seq[d][s] = 0;
        len[d][s] = 0;
        idx[d][s] = 0;
        seed[d][s] = '0;
        lkeep[d][s] = '0;
        s_tdata[d][s] = '0;
        s_tkeep[d][s] = '0;
      end
    end
    clear_sources();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    run(200, 100, 100, 0);
    run(800, 30, 70, 1);
    run(300, 50, 100, 2);

    // Reset in the middle of an s0 frame on the round-robin instance
    start_pct = 100; valid_pct = 100; rdy_mode = 0;
    hit = 1'b0;
    for (int k = 0; k < 400 && !hit; k++) begin
      step_all();
      hit = (act[0][0] != 0) && (idx[0][0] == 1);
    end
    rst = 1'b1;
    clear_sources();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    run(600, 40, 80, 1);

    stop_gen = 1'b1;
    valid_pct = 100;
    rdy_mode = 0;
    busy = 1'b1;
    for (int k = 0; k < 3000 && busy; k++) begin
      step_all();
      busy = 1'b0;
      for (int d = 0; d < 2; d++)
        for (int s = 0; s < 2; s++)
          if (act[d][s] != 0) busy = 1'b1;
    end
    drain_to = busy;
    repeat (10) step_all();
    done = 1'b1;
  end

  // ------------------------------------------------------------------
  // Monitor: frame-level reference model and scoreboard comparisons
  // ------------------------------------------------------------------
  int          m_mode [2];
  int          m_src  [2];
  int          m_last [2];
  int unsigned m_fc   [2][2];
  int unsigned m_tc   [2];

  task automatic chk(input string name, input int d, input logic [63:0] act_v, input logic [63:0] exp_v);
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, d, act_v, exp_v, $time);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_mode[d] = MD_IDLE;
      m_src[d]  = 0;
      m_last[d] = 1;
      m_fc[d][0] = 0;
      m_fc[d][1] = 0;
      m_tc[d] = 0;
    end
  endtask

  task automatic model_step(input int d);
    int    w;
    beat_t e;
    chk("frame_cnt0", d, 64'(o_fc0[d]), 64'(m_fc[d][0]));
    chk("frame_cnt1", d, 64'(o_fc1[d]), 64'(m_fc[d][1]));
    chk("trunc_cnt",  d, 64'(o_tc[d]),  64'(m_tc[d]));
    case (m_mode[d])
      MD_IDLE: begin
        chk("idle_m_tvalid", d, 64'(o_m_tvalid[d]), 64'd0);
        chk("idle_s0_tready", d, 64'(o_s_tready[d][0]), 64'd0);
        chk("idle_s1_tready", d, 64'(o_s_tready[d][1]), 64'd0);
        if (s_tvalid[d][0] || s_tvalid[d][1]) begin
          if (s_tvalid[d][0] && s_tvalid[d][1])
            w = (d == 1) ? 1 : ((m_last[d] == 0) ? 1 : 0);
          else
            w = s_tvalid[d][1] ? 1 : 0;
          m_mode[d] = MD_BUSY;
          m_src[d]  = w;
          m_last[d] = w;
        end
      end
      MD_BUSY: begin
        w = m_src[d];
        chk("grant_m_tvalid", d, 64'(o_m_tvalid[d]), 64'(s_tvalid[d][w]));
        chk("grant_tready", d, 64'(o_s_tready[d][w]), 64'(m_tready[d]));
        chk("other_tready", d, 64'(o_s_tready[d][1-w]), 64'd0);
        if (o_m_tvalid[d] && m_tready[d]) begin
          chk("beat_expected", d, 64'(exp_q[d][w].size() > 0), 64'd1);
          if (exp_q[d][w].size() > 0) begin
            e = exp_q[d][w].pop_front();
            chk("m_tdata", d, o_m_tdata[d], e.data);
            chk("m_tkeep", d, 64'(o_m_tkeep[d]), 64'(e.keep));
            chk("m_tlast", d, 64'(o_m_tlast[d]), 64'(e.last));
            chk("m_tuser", d, 64'(o_m_tuser[d]), 64'(e.user));
            if (e.last) begin
              if (e.user) begin
                m_tc[d] = m_tc[d] + 1;
                m_mode[d] = MD_FLUSH;
              end else begin
                m_fc[d][w] = m_fc[d][w] + 1;
                m_mode[d] = MD_IDLE;
              end
            end
          end
        end
      end
      default: begin
        w = m_src[d];
        chk("flush_m_tvalid", d, 64'(o_m_tvalid[d]), 64'd0);
        chk("flush_tready", d, 64'(o_s_tready[d][w]), 64'd1);
        chk("flush_other_tready", d, 64'(o_s_tready[d][1-w]), 64'd0);
        if (s_tvalid[d][w] && s_tlast[d][w]) m_mode[d] = MD_IDLE;
      end
    endcase
  endtask

  initial begin
    model_reset();
    while (!done) begin
      @(negedge clk);
      if (rst) model_reset();
      else for (int d = 0; d < 2; d++) model_step(d);
    end
    chk("drain_timeout", 0, 64'(drain_to), 64'd0);
    for (int d = 0; d < 2; d++)
      for (int s = 0; s < 2; s++)
        chk("leftover_beats", d, 64'(exp_q[d][s].size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
